// File: rtl/parametrik_denetim_birimi_pkg.sv
// Shared encodings for the hazard/forwarding control unit: stage indices,
// forwarding-select encoding and the per-cycle invalid-mask update modes.
package parametrik_denetim_birimi_pkg;

  localparam int YON_HICBISEY  = 0;
  localparam int ASAMA_GETIR   = 0;
  localparam int ASAMA_COZ     = 1;
  localparam int ASAMA_KAYNAK0 = 2;

  // Forwarding source k is encoded as k+1 on the select outputs.
  function automatic int kaynak_secim(input int k);
    return k + 1;
  endfunction

  typedef enum logic [1:0] {
    GUNCELLE_YANLIS,
    GUNCELLE_YRT_BEKLE,
    GUNCELLE_BALON,
    GUNCELLE_KAYDIR
  } gecersiz_mod_e;

endpackage

// File: rtl/parametrik_denetim_birimi_yonlendirme_secici.sv
// One-operand forwarding priority encoder: youngest valid matching source wins,
// and it reports whether that source is still waiting for its value.
module parametrik_denetim_birimi_yonlendirme_secici
  import parametrik_denetim_birimi_pkg::*;
#(
  parameter int YON_KAYNAK = 3,
  parameter int ADRES_W    = 5,
  parameter int SEL_W      = $clog2(YON_KAYNAK + 1)
) (
  input  logic [ADRES_W-1:0]            rs,
  input  logic                          kullan,
  input  logic [YON_KAYNAK-1:0]         kaynak_yaz,
  input  logic [YON_KAYNAK*ADRES_W-1:0] kaynak_rd,
  input  logic [YON_KAYNAK-1:0]         kaynak_hazir,
  input  logic [YON_KAYNAK-1:0]         kaynak_gecerli,
  output logic [SEL_W-1:0]              secim,
  output logic                          hazir_degil,
  output logic                          hazir_vurus
);

  logic [YON_KAYNAK-1:0] eslesme;

  always_comb begin
    eslesme = '0;
    for (int k = 0; k < YON_KAYNAK; k++) begin
      eslesme[k] = kullan && (rs != '0) && kaynak_yaz[k] && kaynak_gecerli[k] &&
                   (rs == kaynak_rd[k*ADRES_W +: ADRES_W]);
    end
  end

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    secim       = SEL_W'(YON_HICBISEY);
    hazir_degil = 1'b0;
    // Walk from oldest to youngest so the youngest match overwrites the rest.
    for (int k = YON_KAYNAK - 1; k >= 0; k--) begin
      if (eslesme[k]) begin
        secim       = SEL_W'(kaynak_secim(k));
        hazir_degil = ~kaynak_hazir[k];
      end
    end
  end

  assign hazir_vurus = |(eslesme & kaynak_hazir);

endmodule

// File: rtl/parametrik_denetim_birimi.sv
// Hazard/forwarding/stall controller for the in-order core with a multi-cycle
// result scoreboard, post-reset flush window and stall-cycle counter.
module parametrik_denetim_birimi
  import parametrik_denetim_birimi_pkg::*;
#(
  parameter int YON_KAYNAK       = 3,
  parameter int ADRES_W          = 5,
  parameter int YAZMAC_SAYISI    = 32,
  parameter int BOS_BASLA_CEVRIM = 2,
  parameter int SAYAC_W          = 32,
  localparam int SEL_W           = $clog2(YON_KAYNAK + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          gtr_yanlis_tahmin_i,
  input  logic                          gtr_hazir_i,
  output logic                          gtr_durdur_o,
  output logic                          gtr_bosalt_o,
  input  logic [ADRES_W-1:0]            cyo_rs1_adres_i,
  input  logic [ADRES_W-1:0]            cyo_rs2_adres_i,
  input  logic                          cyo_rs1_kullan_i,
  input  logic                          cyo_rs2_kullan_i,
  input  logic                          cyo_uzun_i,
  input  logic [ADRES_W-1:0]            cyo_rd_adres_i,
  output logic [SEL_W-1:0]              cyo_yonlendir_kontrol1_o,
  output logic [SEL_W-1:0]              cyo_yonlendir_kontrol2_o,
  output logic                          cyo_durdur_o,
  output logic                          cyo_bosalt_o,
  input  logic [YON_KAYNAK-1:0]         kaynak_yaz_yazmac_i,
  input  logic [YON_KAYNAK*ADRES_W-1:0] kaynak_rd_adres_i,
  input  logic [YON_KAYNAK-1:0]         kaynak_deger_hazir_i,
  input  logic                          yrt_hazir_i,
  input  logic                          uzun_bitti_i,
  input  logic [ADRES_W-1:0]            uzun_bitti_rd_i,
  output logic [SAYAC_W-1:0]            durdur_sayac_o
);

  localparam int ASAMA = YON_KAYNAK + 2;
  localparam int BOS_W = $clog2(BOS_BASLA_CEVRIM + 1);

  logic [ASAMA-1:0]         gecersiz, gecersiz_d;
  logic [YAZMAC_SAYISI-1:0] mesgul;
  logic [BOS_W-1:0]         bos_sayac;
  logic [YON_KAYNAK-1:0]    kaynak_gecerli;
  logic                     hazir_degil1, hazir_degil2, hazir_vurus1, hazir_vurus2;
  logic                     skor1, skor2, waw, durdur, bosalt, ihrac;
  gecersiz_mod_e            mod;

  assign kaynak_gecerli = ~gecersiz[ASAMA-1:ASAMA_KAYNAK0];

  parametrik_denetim_birimi_yonlendirme_secici #(
    .YON_KAYNAK(YON_KAYNAK), .ADRES_W(ADRES_W), .SEL_W(SEL_W)
  ) u_secici1 (
    .rs(cyo_rs1_adres_i), .kullan(cyo_rs1_kullan_i), .kaynak_yaz(kaynak_yaz_yazmac_i),
    .kaynak_rd(kaynak_rd_adres_i), .kaynak_hazir(kaynak_deger_hazir_i),
    .kaynak_gecerli(kaynak_gecerli), .secim(cyo_yonlendir_kontrol1_o),
    .hazir_degil(hazir_degil1), .hazir_vurus(hazir_vurus1)
  );

  parametrik_denetim_birimi_yonlendirme_secici #(
    .YON_KAYNAK(YON_KAYNAK), .ADRES_W(ADRES_W), .SEL_W(SEL_W)
  ) u_secici2 (
    .rs(cyo_rs2_adres_i), .kullan(cyo_rs2_kullan_i), .kaynak_yaz(kaynak_yaz_yazmac_i),
    .kaynak_rd(kaynak_rd_adres_i), .kaynak_hazir(kaynak_deger_hazir_i),
    .kaynak_gecerli(kaynak_gecerli), .secim(cyo_yonlendir_kontrol2_o),
    .hazir_degil(hazir_degil2), .hazir_vurus(hazir_vurus2)
  );

  // A completion in this very cycle releases the busy bit early (bypass).
  assign skor1 = cyo_rs1_kullan_i && (cyo_rs1_adres_i != '0) && mesgul[cyo_rs1_adres_i] &&
                 !(uzun_bitti_i && (uzun_bitti_rd_i == cyo_rs1_adres_i)) && !hazir_vurus1;
  assign skor2 = cyo_rs2_kullan_i && (cyo_rs2_adres_i != '0) && mesgul[cyo_rs2_adres_i] &&
                 !(uzun_bitti_i && (uzun_bitti_rd_i == cyo_rs2_adres_i)) && !hazir_vurus2;
  assign waw   = cyo_uzun_i && mesgul[cyo_rd_adres_i];

  assign durdur = !yrt_hazir_i || !gtr_hazir_i || hazir_degil1 || hazir_degil2 ||
                  skor1 || skor2 || waw;
  assign bosalt = (bos_sayac != '0) || gtr_yanlis_tahmin_i;
  assign ihrac  = cyo_uzun_i && !durdur && !bosalt && (cyo_rd_adres_i != '0);

  assign cyo_durdur_o = durdur;
  assign gtr_durdur_o = durdur;
  assign cyo_bosalt_o = bosalt;
  assign gtr_bosalt_o = bosalt;

  always_comb begin
    if (gtr_yanlis_tahmin_i) mod = GUNCELLE_YANLIS;
    else if (!yrt_hazir_i)   mod = GUNCELLE_YRT_BEKLE;
    else if (durdur)         mod = GUNCELLE_BALON;
    else                     mod = GUNCELLE_KAYDIR;
  end

  // Invalid mask advances with the pipeline; held stages keep their bit, bubbles insert 1.
  always_comb begin
    gecersiz_d = '0;
    for (int i = 1; i < ASAMA; i++) begin
      gecersiz_d[i] = gecersiz[i-1];
      unique case (mod)
        GUNCELLE_YANLIS:    if (i <= ASAMA_KAYNAK0) gecersiz_d[i] = 1'b1;
        GUNCELLE_YRT_BEKLE: begin
          if (i <= ASAMA_KAYNAK0)          gecersiz_d[i] = gecersiz[i];
          else if (i == ASAMA_KAYNAK0 + 1) gecersiz_d[i] = 1'b1;
        end
        GUNCELLE_BALON: begin
          if (i == ASAMA_COZ)          gecersiz_d[i] = gecersiz[i];
          else if (i == ASAMA_KAYNAK0) gecersiz_d[i] = 1'b1;
        end
        GUNCELLE_KAYDIR: ;
      endcase
    end
    gecersiz_d[ASAMA_GETIR] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gecersiz       <= '1;
      // NOTE: the scoreboard is a flop vector, not a RAM, so it can and must be reset.
      mesgul         <= '0;
      bos_sayac      <= BOS_W'(BOS_BASLA_CEVRIM);
      durdur_sayac_o <= '0;
    end else begin
      gecersiz <= gecersiz_d;
      if (bos_sayac != '0) bos_sayac <= bos_sayac - 1'b1;
      // Issue is written after completion so a same-register set wins.
      if (uzun_bitti_i) mesgul[uzun_bitti_rd_i] <= 1'b0;
      if (ihrac)        mesgul[cyo_rd_adres_i]  <= 1'b1;
      if (durdur && !bosalt) durdur_sayac_o <= durdur_sayac_o + SAYAC_W'(1);
    end
  end

endmodule
